// File: rtl/sw_job_scheduler_if.sv
// Bus bundle between the job scheduler and its sequence memory, accelerator and result RAM.
// The scheduler takes the master side; the memory/accelerator/RAM environment takes the slave side.
interface sw_job_scheduler_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned SEQ_W  = 24,
  parameter int unsigned ALN_W  = 30
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [SEQ_W-1:0]  mem_r;
  logic [SEQ_W-1:0]  mem_q;
  logic              acc_start;
  logic [SEQ_W-1:0]  acc_R;
  logic [SEQ_W-1:0]  acc_Q;
  logic [ALN_W-1:0]  acc_r_aln;
  logic [ALN_W-1:0]  acc_q_aln;
  logic              acc_ready;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
  logic [ALN_W-1:0]  res_r;
  logic [ALN_W-1:0]  res_q;

  modport master (
    output mem_addr, acc_start, acc_R, acc_Q, res_we, res_addr, res_r, res_q,
    input  mem_r, mem_q, acc_r_aln, acc_q_aln, acc_ready
  );

  modport slave (
    input  mem_addr, acc_start, acc_R, acc_Q, res_we, res_addr, res_r, res_q,
    output mem_r, mem_q, acc_r_aln, acc_q_aln, acc_ready
  );
endinterface

// File: rtl/sw_job_scheduler.sv
// Batch sequencer for the banded Smith-Waterman accelerator: fetch R/Q per job, launch,
// wait for a fresh ready edge (or time out) and write the aligned pair to the result buffer.
module sw_job_scheduler #(
  parameter int unsigned NUM_JOBS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned SEQ_W    = 24,
  parameter int unsigned ALN_W    = 30,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  sw_job_scheduler_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ADDR_W:0]   jobs_done
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned JD_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic              ready_q;
  logic              edge_c;
  logic              tmo_c;
  logic              last_c;

  assign bus.mem_addr = idx;

  // Next-state logic; only a rising ready edge counts, so a level left over from the previous job is ignored.
  always_comb begin
    state_nx = state;
    edge_c   = bus.acc_ready & ~ready_q;
    tmo_c    = (wait_cnt == CNT_W'(TIMEOUT - 1));
    last_c   = (idx == ADDR_W'(NUM_JOBS - 1));
    unique case (state)
      S_IDLE:   if (go) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT:   if (edge_c || tmo_c) state_nx = S_STORE;
      S_STORE:  state_nx = last_c ? S_DONE : S_FETCH;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      wait_cnt      <= '0;
      ready_q       <= 1'b0;
      bus.acc_start <= 1'b0;
      bus.acc_R     <= '0;
      bus.acc_Q     <= '0;
      bus.res_we    <= 1'b0;
      bus.res_addr  <= '0;
      bus.res_r     <= '0;
      bus.res_q     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      jobs_done     <= '0;
    end else begin
      state         <= state_nx;
      ready_q       <= bus.acc_ready;
      bus.acc_start <= (state_nx == S_LAUNCH);
      bus.res_we    <= (state_nx == S_STORE);
      done          <= (state_nx == S_DONE);
      busy          <= (state_nx != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (go) begin
            idx         <= '0;
            jobs_done   <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_FETCH: begin
          bus.acc_R <= bus.mem_r;
          bus.acc_Q <= bus.mem_q;
        end
        S_LAUNCH: wait_cnt <= '0;
        S_WAIT: begin
          // Edge beats a simultaneous timeout: the real result is kept and no error is flagged.
          if (edge_c) begin
            bus.res_r    <= bus.acc_r_aln;
            bus.res_q    <= bus.acc_q_aln;
            bus.res_addr <= idx;
          end else if (tmo_c) begin
            bus.res_r    <= '0;
            bus.res_q    <= '0;
            bus.res_addr <= idx;
            timeout_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_STORE: begin
          jobs_done <= jobs_done + JD_W'(1);
          if (!last_c) idx <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sw_job_scheduler.sv
// Directed bench for sw_job_scheduler: scenario table of batches against a mock accelerator,
// plus hand-written reset sequences.
module tb_sw_job_scheduler;
  localparam int unsigned NJ = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned SW = 24;
  localparam int unsigned LW = 30;
  localparam int unsigned TO = 1023;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [AW:0]   jobs_done;

  sw_job_scheduler_if #(.ADDR_W(AW), .SEQ_W(SW), .ALN_W(LW)) bus ();

  sw_job_scheduler #(
    .NUM_JOBS(NJ), .ADDR_W(AW), .SEQ_W(SW), .ALN_W(LW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .bus(bus.master),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Sequence memory: R = job index, Q = its complement
  assign bus.mem_r = SW'(bus.mem_addr);
  assign bus.mem_q = ~SW'(bus.mem_addr);

  // Mock accelerator: aligned outputs tag the held R/Q; ready rises lat_tab[job] cycles after start
  assign bus.acc_r_aln = {6'h15, bus.acc_R};
  assign bus.acc_q_aln = {6'h2A, bus.acc_Q};

  int          lat_tab [NJ];
  bit          hold_mode;
  logic [AW-1:0] m_job;
  int          m_cnt;
  bit          m_run;
  bit          rose;

  always @(posedge clk) begin
    if (reset) begin
      bus.acc_ready <= 1'b0;
      m_run <= 1'b0;
      m_cnt <= 0;
      rose  <= 1'b0;
      m_job <= '0;
    end else if (bus.acc_start) begin
      m_job <= bus.acc_R[AW-1:0];
      m_cnt <= 0;
      m_run <= 1'b1;
      rose  <= 1'b0;
      if (!hold_mode) bus.acc_ready <= 1'b0;
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if (hold_mode && (m_cnt + 1 == 2)) bus.acc_ready <= 1'b0;
      if (lat_tab[m_job] != 0 && (m_cnt + 1 == lat_tab[m_job])) begin
        bus.acc_ready <= 1'b1;
        rose  <= 1'b1;
        m_run <= 1'b0;
      end
    end
  end

  typedef struct {
    string name;
    int    lat0;
    int    lat_other;
    int    stall_job;
    bit    hold;
    bit    go_again;
    int    exp_writes;
    bit    exp_tmo;
  } scen_t;

  scen_t tab [4];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_scen(input scen_t s);
    int writes = 0;
    int starts = 0;
    int dones = 0;
    int start_c = 0;
    int lat;
    bit fin = 0;
    logic [AW-1:0] next_addr = '0;
    logic [SW-1:0] rr;
    logic [LW-1:0] er;
    logic [LW-1:0] eq;
    hold_mode = s.hold;
    for (int j = 0; j < NJ; j++) begin
      lat_tab[j] = (j == 0) ? s.lat0 : s.lat_other;
      if (j == s.stall_job) lat_tab[j] = 0;
    end
    @(negedge clk);
    go = 1'b1;
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(negedge clk);
      go = (s.go_again && c == 50);
      if (c == 0) begin
        chk({s.name, "_first_busy"}, 64'(busy), 64'd1);
        chk({s.name, "_first_mem_addr"}, 64'(bus.mem_addr), 64'd0);
      end
      if (bus.acc_start) begin
        starts++;
        start_c = c;
      end
      if (bus.res_we) begin
        lat = lat_tab[next_addr];
        rr = SW'(next_addr);
        er = (lat == 0) ? '0 : {6'h15, rr};
        eq = (lat == 0) ? '0 : {6'h2A, ~rr};
        chk({s.name, "_res_addr"}, 64'(bus.res_addr), 64'(next_addr));
        chk({s.name, "_res_r"}, 64'(bus.res_r), 64'(er));
        chk({s.name, "_res_q"}, 64'(bus.res_q), 64'(eq));
        chk({s.name, "_latency"}, 64'(c - start_c), 64'((lat == 0) ? TO + 1 : lat + 2));
        chk({s.name, "_fresh_rise"}, 64'(rose), 64'(lat != 0));
        writes++;
        next_addr = next_addr + AW'(1);
      end
      if (done) begin
        dones++;
        fin = 1;
        chk({s.name, "_jobs_done"}, 64'(jobs_done), 64'(NJ));
        chk({s.name, "_timeout_err"}, 64'(timeout_err), 64'(s.exp_tmo));
      end
    end
    go = 1'b0;
    chk({s.name, "_done_seen"}, 64'(fin), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (bus.res_we) writes++;
      if (c == 0) chk({s.name, "_idle_busy"}, 64'(busy), 64'd0);
    end
    chk({s.name, "_writes"}, 64'(writes), 64'(s.exp_writes));
    chk({s.name, "_starts"}, 64'(starts), 64'(NJ));
    chk({s.name, "_dones"}, 64'(dones), 64'd1);
    chk({s.name, "_hold_jobs_done"}, 64'(jobs_done), 64'(NJ));
    chk({s.name, "_hold_tmo"}, 64'(timeout_err), 64'(s.exp_tmo));
  endtask

  initial begin
    int starts;
    int stray;
    tab[0] = '{"normal",    40,   40,  -1, 1'b0, 1'b1, 8, 1'b0};
    tab[1] = '{"hold",      10,   10,  -1, 1'b1, 1'b0, 8, 1'b0};
    tab[2] = '{"stall3",     6,    6,   3, 1'b0, 1'b0, 8, 1'b1};
    tab[3] = '{"collide", 1022,    4,  -1, 1'b0, 1'b0, 8, 1'b0};
    hold_mode = 1'b0;
    for (int j = 0; j < NJ; j++) lat_tab[j] = 40;

    // Reset held 3 cycles with go asserted
    reset = 1'b1;
    go    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tmo", 64'(timeout_err), 64'd0);
    chk("rst_jobs_done", 64'(jobs_done), 64'd0);
    chk("rst_acc_start", 64'(bus.acc_start), 64'd0);
    chk("rst_res_we", 64'(bus.res_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_acc_R", 64'(bus.acc_R), 64'd0);
    chk("rst_res_r", 64'(bus.res_r), 64'd0);
    reset = 1'b0;
    go    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_go_ignored", 64'(busy), 64'd0);

    for (int k = 0; k < 4; k++) run_scen(tab[k]);

    // Reset during WAIT of job 5
    for (int j = 0; j < NJ; j++) lat_tab[j] = 40;
    hold_mode = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    starts = 0;
    for (int c = 0; c < 2000 && starts < 6; c++) begin
      @(negedge clk);
      if (bus.acc_start) starts++;
    end
    chk("midrst_reached_job5", 64'(starts), 64'd6);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_res_we", 64'(bus.res_we), 64'd0);
    chk("midrst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("midrst_jobs_done", 64'(jobs_done), 64'd0);
    stray = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.res_we || busy) stray++;
    end
    chk("midrst_quiet", 64'(stray), 64'd0);
    run_scen(tab[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
